e203_csr_port_arbiter: RTL

Arbiter and sequencer for the single CSR register-file access port. Two requesters share it: the core CSR-instruction path from the ALU CSR control stage, which is combinational with single-cycle accesses, and the debug-module abstract-command path, which uses a valid/ready request/response handshake. The block sits between the EXU CSR control logic and the CSR register file. It grants the port per cycle, issues buffered debug accesses and holds debug responses until they are consumed.

---
 rtl/e203_csr_arb_pkg.sv | 17 +
 rtl/e203_csr_arb_starve_cnt.sv | 46 ++++
 rtl/e203_csr_port_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/e203_csr_arb_pkg.sv
// ---------------------------------------------------------------------------
// e203_csr_arb_pkg
// Shared definitions for the CSR port arbiter: data width, arbiter state
// encoding and the width of the debug starvation counter.
// ---------------------------------------------------------------------------
package e203_csr_arb_pkg;

    localparam int E203_XLEN    = 32;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_DBG_ISS = 2'd1,
        ARB_DBG_RSP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/e203_csr_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// e203_csr_arb_starve_cnt
// Saturating counter of cycles a debug request has been refused. It flags
// starvation once the count reaches STARVE_LIMIT.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   cnt_inc     debug request refused this cycle (IDLE, valid, not ready)
//   cnt_clr     debug request accepted or withdrawn
//   starve      count has reached STARVE_LIMIT
// ---------------------------------------------------------------------------
module e203_csr_arb_starve_cnt
    import e203_csr_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_inc,
    input  logic cnt_clr,
    output logic starve
);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve = (cnt_q == STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/e203_csr_port_arbiter.sv
// ---------------------------------------------------------------------------
// e203_csr_port_arbiter
// Shares the single CSR register-file port between the core CSR-instruction
// path (combinational, single cycle) and the debug-module abstract-command
// path (valid/ready request and response).
//
// Optional feature macro: E203_CSR_ARB_STARVE_EN
//   defined   - debug wins over the core after STARVE_LIMIT refused cycles
//   undefined - core has strict priority, no starvation counter
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   core_req_valid/ready               core access request / grant
//   core_wr_en, core_rd_en, core_idx,
//   core_wdat                          core access fields
//   core_rdat, core_ilgl               read data / illegal flag to the core
//   dbg_req_valid/ready, dbg_req_wr,
//   dbg_req_idx, dbg_req_wdat          debug request channel
//   dbg_rsp_valid/ready, dbg_rsp_rdat,
//   dbg_rsp_err                        debug response channel
//   csr_ena, csr_wr_en, csr_rd_en,
//   csr_idx, wbck_csr_dat              port toward the CSR file
//   read_csr_dat, csr_access_ilgl      port return from the CSR file
//
// State | meaning
// IDLE    | core owns the port; a debug request may be accepted
// DBG_ISS | registered debug access is on the port; core stalled
// DBG_RSP | debug response held until consumed; core owns the port
// ---------------------------------------------------------------------------
module e203_csr_port_arbiter
    import e203_csr_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 core_req_valid,
    output logic                 core_req_ready,
    input  logic                 core_wr_en,
    input  logic                 core_rd_en,
    input  logic [11:0]          core_idx,
    input  logic [E203_XLEN-1:0] core_wdat,
    output logic [E203_XLEN-1:0] core_rdat,
    output logic                 core_ilgl,

    input  logic                 dbg_req_valid,
    output logic                 dbg_req_ready,
    input  logic                 dbg_req_wr,
    input  logic [11:0]          dbg_req_idx,
    input  logic [E203_XLEN-1:0] dbg_req_wdat,
    output logic                 dbg_rsp_valid,
    input  logic                 dbg_rsp_ready,
    output logic [E203_XLEN-1:0] dbg_rsp_rdat,
    output logic                 dbg_rsp_err,

    output logic                 csr_ena,
    output logic                 csr_wr_en,
    output logic                 csr_rd_en,
    output logic [11:0]          csr_idx,
    output logic [E203_XLEN-1:0] wbck_csr_dat,
    input  logic [E203_XLEN-1:0] read_csr_dat,
    input  logic                 csr_access_ilgl
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..255");
    end

    arb_state_e             state_q, state_d;
    logic [11:0]            dbg_idx_q, dbg_idx_d;
    logic [E203_XLEN-1:0]   dbg_wdat_q, dbg_wdat_d;
    logic                   dbg_wr_q, dbg_wr_d;
    logic [E203_XLEN-1:0]   rsp_rdat_q, rsp_rdat_d;
    logic                   rsp_err_q, rsp_err_d;

    logic starve;
    logic dbg_accept;

    // Handshake outputs are gated with rst_n so nothing is offered while
    // reset is held, even before the first reset edge has cleared state.
    assign dbg_req_ready  = rst_n & (state_q == ARB_IDLE) & (~core_req_valid | starve);
    assign dbg_accept     = dbg_req_valid & dbg_req_ready;
    assign core_req_ready = rst_n & (state_q != ARB_DBG_ISS);
    assign dbg_rsp_valid  = rst_n & (state_q == ARB_DBG_RSP);
    assign dbg_rsp_rdat   = rsp_rdat_q;
    assign dbg_rsp_err    = rsp_err_q;
    assign core_rdat      = read_csr_dat;
    assign core_ilgl      = csr_access_ilgl;

`ifdef E203_CSR_ARB_STARVE_EN
    e203_csr_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_inc ((state_q == ARB_IDLE) & dbg_req_valid & ~dbg_req_ready),
        .cnt_clr (dbg_accept | ~dbg_req_valid),
        .starve  (starve)
    );
`else
    assign starve = 1'b0;
`endif

    // Port mux: the debug access owns the port only in DBG_ISS; otherwise the
    // core mirrors straight through. An invalid core request drives all zero.
    always_comb begin
        csr_ena      = 1'b0;
        csr_wr_en    = 1'b0;
        csr_rd_en    = 1'b0;
        csr_idx      = '0;
        wbck_csr_dat = '0;
        if (rst_n) begin
            if (state_q == ARB_DBG_ISS) begin
                csr_ena      = 1'b1;
                csr_rd_en    = 1'b1;
                csr_wr_en    = dbg_wr_q;
                csr_idx      = dbg_idx_q;
                wbck_csr_dat = dbg_wdat_q;
            end else if (core_req_valid) begin
                csr_ena      = 1'b1;
                csr_wr_en    = core_wr_en;
                csr_rd_en    = core_rd_en;
                csr_idx      = core_idx;
                wbck_csr_dat = core_wdat;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dbg_idx_d  = dbg_idx_q;
        dbg_wdat_d = dbg_wdat_q;
        dbg_wr_d   = dbg_wr_q;
        rsp_rdat_d = rsp_rdat_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (dbg_accept) begin
                    dbg_idx_d  = dbg_req_idx;
                    dbg_wdat_d = dbg_req_wdat;
                    dbg_wr_d   = dbg_req_wr;
                    state_d    = ARB_DBG_ISS;
                end
            end
            ARB_DBG_ISS: begin
                rsp_rdat_d = read_csr_dat;
                rsp_err_d  = csr_access_ilgl;
                state_d    = ARB_DBG_RSP;
            end
            ARB_DBG_RSP: begin
                if (dbg_rsp_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            dbg_idx_q  <= '0;
            dbg_wdat_q <= '0;
            dbg_wr_q   <= 1'b0;
            rsp_rdat_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dbg_idx_q  <= dbg_idx_d;
            dbg_wdat_q <= dbg_wdat_d;
            dbg_wr_q   <= dbg_wr_d;
            rsp_rdat_q <= rsp_rdat_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule
